// File: rtl/ifu_fetch_queue_if.sv
// Fetch-queue bus bundle: imem request/response channel and decode handshake.
// master = fetch unit side, slave = memory/decode environment side.

`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

interface ifu_fetch_queue_if #(
  parameter int unsigned FETCH_WIDTH     = `FETCH_WIDTH,
  parameter int unsigned INST_ADDR_WIDTH = `INST_ADDR_WIDTH
);
  logic                         imem_req_valid;
  logic                         imem_req_ready;
  logic [INST_ADDR_WIDTH-1:0]   imem_req_addr;
  logic                         imem_resp_valid;
  logic [32*FETCH_WIDTH-1:0]    imem_resp_data;
  logic                         dec_valid;
  logic                         dec_ready;
  logic [32*FETCH_WIDTH-1:0]    dec_inst;
  logic [FETCH_WIDTH-1:0]       dec_slot_valid;
  logic [INST_ADDR_WIDTH-1:0]   dec_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output dec_valid, dec_inst, dec_slot_valid, dec_pc,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  dec_valid, dec_inst, dec_slot_valid, dec_pc,
    output dec_ready
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue: issues bundle-aligned imem requests with several
// outstanding, buffers responses in a FIFO and presents the head to decode.
// Handles redirect/flush, unaligned redirect targets and end-of-code halt.
// Optional macro IFU_PERF_CNT_EN instantiates the performance counters;
// without it the perf_* ports are tied to zero.

`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module ifu_fetch_queue #(
  parameter int unsigned FETCH_WIDTH     = `FETCH_WIDTH,
  parameter int unsigned INST_ADDR_WIDTH = `INST_ADDR_WIDTH,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       redirect_valid,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
  ifu_fetch_queue_if.master          bus_io,
  output logic                       fetch_halted,
  output logic [31:0]                perf_bundles,
  output logic [31:0]                perf_stall_cycles,
  output logic [15:0]                perf_flushes
);

  localparam int unsigned DataW       = 32 * FETCH_WIDTH;
  localparam int unsigned BundleBytes = 4 * FETCH_WIDTH;
  localparam int unsigned PtrW        = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW        = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned OutW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [INST_ADDR_WIDTH-1:0] AddrLowMask = INST_ADDR_WIDTH'(BundleBytes - 1);
  localparam logic [INST_ADDR_WIDTH-1:0] AddrStep    = INST_ADDR_WIDTH'(BundleBytes);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e                     state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [INST_ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [OutW-1:0]            outstanding_q, outstanding_d;
  logic [OutW-1:0]            drop_q, drop_d;
  logic [FETCH_WIDTH-1:0]     first_mask_q, first_mask_d;
  logic                       halted_q, halted_d;
  logic [CntW-1:0]            count_q, count_d;
  logic [PtrW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;

  logic [DataW-1:0]           inst_mem [QUEUE_DEPTH];
  logic [INST_ADDR_WIDTH-1:0] pc_mem   [QUEUE_DEPTH];
  logic [FETCH_WIDTH-1:0]     mask_mem [QUEUE_DEPTH];

  logic                       req_valid, req_accept, resp_keep;
  logic                       push, pop, flush, eoc_found;
  logic [FETCH_WIDTH-1:0]     resp_mask, redirect_mask;
  logic [INST_ADDR_WIDTH-1:0] redirect_base, redirect_slot;
  logic                       dec_valid;

  // Request issue: credit check so every response is guaranteed a queue slot.
  always_comb begin
    req_valid  = (state_q == StRun) && !redirect_valid &&
                 (32'(outstanding_q) < MAX_OUTSTANDING) &&
                 ((32'(count_q) + 32'(outstanding_q)) < QUEUE_DEPTH);
    req_accept = req_valid && bus_io.imem_req_ready;
  end

  // End-of-code scan: first valid all-zero slot kills itself and every later slot.
  always_comb begin
    eoc_found = 1'b0;
    resp_mask = first_mask_q;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!eoc_found && first_mask_q[i] && (bus_io.imem_resp_data[32*i +: 32] == 32'h0)) begin
        eoc_found = 1'b1;
      end
      if (eoc_found) begin
        resp_mask[i] = 1'b0;
      end
    end
  end

  // Redirect target split into bundle base and starting-slot mask.
  always_comb begin
    redirect_base = redirect_pc & ~AddrLowMask;
    redirect_slot = (redirect_pc >> 2) & INST_ADDR_WIDTH'(FETCH_WIDTH - 1);
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      redirect_mask[i] = (INST_ADDR_WIDTH'(i) >= redirect_slot);
    end
  end

  // Control next-state: fetch PC, credits, drop count, halt and redirect handling.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    first_mask_d  = first_mask_q;
    halted_d      = halted_q;
    push          = 1'b0;
    pop           = dec_valid && bus_io.dec_ready;
    flush         = 1'b0;
    resp_keep     = bus_io.imem_resp_valid && (drop_q == '0) && !redirect_valid;

    if (state_q == StIdle) begin
      state_d = StRun;
    end

    if (req_accept) begin
      fetch_pc_d = fetch_pc_q + AddrStep;
    end

    if (req_accept && !bus_io.imem_resp_valid) begin
      outstanding_d = outstanding_q + OutW'(1);
    end else if (!req_accept && bus_io.imem_resp_valid) begin
      outstanding_d = outstanding_q - OutW'(1);
    end

    if (bus_io.imem_resp_valid && (drop_q != '0)) begin
      drop_d = drop_q - OutW'(1);
    end

    if (resp_keep) begin
      resp_pc_d    = resp_pc_q + AddrStep;
      first_mask_d = '1;
      push         = |resp_mask;
      if (eoc_found) begin
        // Everything still in flight belongs past the end of code.
        state_d  = StHalt;
        halted_d = 1'b1;
        drop_d   = outstanding_d;
      end
    end

    if (redirect_valid) begin
      flush        = 1'b1;
      push         = 1'b0;
      pop          = 1'b0;
      state_d      = StRun;
      halted_d     = 1'b0;
      fetch_pc_d   = redirect_base;
      resp_pc_d    = redirect_base;
      first_mask_d = redirect_mask;
      // No request issues this cycle, so this is outstanding minus any response now.
      drop_d       = outstanding_d;
    end
  end

  // Queue pointer and occupancy next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // Control and queue state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      first_mask_q  <= '1;
      halted_q      <= 1'b0;
      count_q       <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      first_mask_q  <= first_mask_d;
      halted_q      <= halted_d;
      count_q       <= count_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
    end
  end

  // Bundle storage; contents only observable while the entry is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wptr_q] <= bus_io.imem_resp_data;
      pc_mem[wptr_q]   <= resp_pc_q;
      mask_mem[wptr_q] <= resp_mask;
    end
  end

  // Outputs: head of queue straight from storage, zeroed when empty.
  always_comb begin
    dec_valid             = (count_q != '0);
    bus_io.dec_valid      = dec_valid;
    bus_io.dec_inst       = dec_valid ? inst_mem[rptr_q] : '0;
    bus_io.dec_slot_valid = dec_valid ? mask_mem[rptr_q] : '0;
    bus_io.dec_pc         = dec_valid ? pc_mem[rptr_q] : '0;
    bus_io.imem_req_valid = req_valid;
    bus_io.imem_req_addr  = fetch_pc_q;
    fetch_halted          = halted_q;
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_bundles_q, perf_bundles_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flushes_q, perf_flushes_d;

  // Saturating event counters.
  always_comb begin
    perf_bundles_d = perf_bundles_q;
    perf_stall_d   = perf_stall_q;
    perf_flushes_d = perf_flushes_q;
    if (push && (perf_bundles_q != '1)) begin
      perf_bundles_d = perf_bundles_q + 32'd1;
    end
    if ((state_q == StRun) && !req_valid && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (redirect_valid && (perf_flushes_q != '1)) begin
      perf_flushes_d = perf_flushes_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_bundles_q <= '0;
      perf_stall_q   <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_bundles_q <= perf_bundles_d;
      perf_stall_q   <= perf_stall_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_bundles      = perf_bundles_q;
  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flushes_q;
`else
  assign perf_bundles      = '0;
  assign perf_stall_cycles = '0;
  assign perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Self-checking bench for ifu_fetch_queue: directed scenarios plus a random
// phase, compared cycle by cycle against a transaction-level queue model.

module tb_ifu_fetch_queue;
  localparam int unsigned FW    = 2;
  localparam int unsigned IAW   = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_halted;
  logic [31:0] perf_bundles, perf_stall_cycles;
  logic [15:0] perf_flushes;

  ifu_fetch_queue_if #(.FETCH_WIDTH(FW), .INST_ADDR_WIDTH(IAW)) bus ();

  ifu_fetch_queue #(
    .FETCH_WIDTH(FW), .INST_ADDR_WIDTH(IAW), .QUEUE_DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .bus_io(bus), .fetch_halted(fetch_halted),
    .perf_bundles(perf_bundles), .perf_stall_cycles(perf_stall_cycles),
    .perf_flushes(perf_flushes)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; } req_t;
  typedef struct { logic [63:0] inst; logic [31:0] pc; logic [1:0] mask; } ent_t;

  req_t infl[$];
  ent_t mq[$];
  int total = 0;
  int bad = 0;

  int          m_state;  // 0 idle, 1 run, 2 halt
  logic [31:0] m_pc;
  int          epoch = 0;
  bit          m_first;
  logic [1:0]  m_first_mask;
  bit          m_halted;
  int          m_flushes, m_bundles, m_stall;

  int          p_ready, p_resp, p_dec, p_redir;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc = '0;
  bit          eoc_en = 1'b0;
  logic [31:0] eoc_pc = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (eoc_en && a == eoc_pc) return 32'h0;
    return 32'hA500_0000 | {8'h0, a[23:0]};
  endfunction

  function automatic bit exp_req_valid();
    return (m_state == 1) && !redirect_valid && (infl.size() < MAXO) &&
           (mq.size() + infl.size() < DEPTH);
  endfunction

  task automatic model_reset();
    infl.delete();
    mq.delete();
    m_state = 0; m_pc = RPC; epoch++; m_first = 1'b0; m_first_mask = 2'b11;
    m_halted = 1'b0; m_flushes = 0; m_bundles = 0; m_stall = 0;
  endtask

  // Called just after a rising edge, while the pre-edge inputs are still applied.
  task automatic model_edge();
    bit          acc, pop_ok, have_resp, found;
    req_t        h;
    logic [1:0]  mask;
    logic [63:0] data;
    int          start;
    acc       = exp_req_valid() && bus.imem_req_ready;
    pop_ok    = (mq.size() > 0) && bus.dec_ready;
    have_resp = bus.imem_resp_valid;
    data      = bus.imem_resp_data;
    if (m_state == 1 && !exp_req_valid()) m_stall++;
    if (have_resp) h = infl.pop_front();
    if (acc) begin
      infl.push_back('{addr: m_pc, epoch: epoch});
      m_pc = m_pc + 32'd8;
    end
    if (redirect_valid) begin
      mq.delete();
      epoch++;
      m_pc = redirect_pc & ~32'd7;
      m_first = 1'b1;
      start = int'((redirect_pc >> 2) % FW);
      for (int s = 0; s < FW; s++) m_first_mask[s] = (s >= start);
      m_halted = 1'b0;
      m_state = 1;
      m_flushes++;
      return;
    end
    if (m_state == 0) m_state = 1;
    if (pop_ok) void'(mq.pop_front());
    if (have_resp && h.epoch == epoch) begin
      mask = m_first ? m_first_mask : 2'b11;
      m_first = 1'b0;
      found = 1'b0;
      for (int s = 0; s < FW; s++) begin
        if (!found && mask[s] && data[32*s +: 32] == 32'h0) begin
          found = 1'b1;
          mask = mask & 2'((1 << s) - 1);
        end
      end
      if (mask != 2'b00) begin
        mq.push_back('{inst: data, pc: h.addr, mask: mask});
        m_bundles++;
      end
      if (found) begin
        m_state = 2; m_halted = 1'b1; epoch++;
      end
    end
  endtask

  task automatic drive_inputs();
    logic [31:0] a;
    bus.imem_req_ready = ($urandom_range(99) < p_ready);
    bus.dec_ready      = ($urandom_range(99) < p_dec);
    if (infl.size() > 0 && $urandom_range(99) < p_resp) begin
      a = infl[0].addr;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = {mem_word(a + 32'd4), mem_word(a)};
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = {$urandom, $urandom};
    end
    if (force_redir) begin
      redirect_valid = 1'b1; redirect_pc = force_pc; force_redir = 1'b0;
    end else if ($urandom_range(99) < p_redir) begin
      redirect_valid = 1'b1; redirect_pc = 32'($urandom_range(0, 255)) << 2;
    end else begin
      redirect_valid = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("req_valid", 64'(bus.imem_req_valid), 64'(exp_req_valid()));
    if (exp_req_valid()) check("req_addr", 64'(bus.imem_req_addr), 64'(m_pc));
    check("dec_valid", 64'(bus.dec_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("dec_inst", bus.dec_inst, mq[0].inst);
      check("dec_pc", 64'(bus.dec_pc), 64'(mq[0].pc));
      check("dec_mask", 64'(bus.dec_slot_valid), 64'(mq[0].mask));
    end
    check("halted", 64'(fetch_halted), 64'(m_halted));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    drive_inputs();
    #1;
    check_outputs();
  endtask

  task automatic post_release();
    drive_inputs();
    #1;
    check_outputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'(0));
    check({tag, "_req_addr"}, 64'(bus.imem_req_addr), 64'(RPC));
    check({tag, "_dec_valid"}, 64'(bus.dec_valid), 64'(0));
    check({tag, "_dec_inst"}, bus.dec_inst, 64'(0));
    check({tag, "_dec_mask"}, 64'(bus.dec_slot_valid), 64'(0));
    check({tag, "_dec_pc"}, 64'(bus.dec_pc), 64'(0));
    check({tag, "_halted"}, 64'(fetch_halted), 64'(0));
    check({tag, "_perf"}, 64'(perf_bundles | perf_stall_cycles | 32'(perf_flushes)), 64'(0));
  endtask

  task automatic wait_outstanding2(input string tag);
    for (int i = 0; i < 12 && infl.size() < 2; i++) step();
    check(tag, 64'(infl.size()), 64'(2));
  endtask

  task automatic set_probs(input int r, input int rs, input int d, input int rd);
    p_ready = r; p_resp = rs; p_dec = d; p_redir = rd;
  endtask

  initial begin
    int lat;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;   bus.dec_ready = 1'b0;
    set_probs(100, 100, 100, 0);
    model_reset();
    #1 reset_n = 1'b0;
    #11;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    post_release();

    // Straight-line fetch with everything ready: first decode 3 edges after release.
    lat = 0;
    for (int i = 0; i < 10 && !bus.dec_valid; i++) begin
      step();
      lat++;
    end
    check("first_dec_latency", 64'(lat), 64'(3));
    repeat (10) step();

    // Decode stalled: queue fills, requests stop, then drains with nothing lost.
    set_probs(100, 100, 0, 0);
    repeat (12) step();
    check("full_no_req", 64'(bus.imem_req_valid), 64'(0));
    check("full_dec_valid", 64'(bus.dec_valid), 64'(1));
    set_probs(100, 100, 100, 0);
    repeat (10) step();

    // Redirect to an odd word with two requests in flight.
    set_probs(100, 0, 100, 0);
    wait_outstanding2("redir_setup");
    force_redir = 1'b1; force_pc = 32'h104;
    step();
    step();
    check("redir_addr", 64'(bus.imem_req_addr), 64'(32'h100));
    set_probs(100, 100, 100, 0);
    repeat (10) step();
`ifdef IFU_PERF_CNT_EN
    check("perf_flushes", 64'(perf_flushes), 64'(m_flushes));
`else
    check("perf_flushes_off", 64'(perf_flushes), 64'(0));
`endif

    // End of code in slot 0: nothing enqueued, halt, then resume by redirect.
    eoc_en = 1'b1; eoc_pc = 32'h208;
    force_redir = 1'b1; force_pc = 32'h200;
    repeat (12) step();
    check("eoc0_halted", 64'(fetch_halted), 64'(1));
    check("eoc0_no_req", 64'(bus.imem_req_valid), 64'(0));
    force_redir = 1'b1; force_pc = 32'h40;
    step();
    step();
    check("resume_addr", 64'(bus.imem_req_addr), 64'(32'h40));
    check("resume_halted", 64'(fetch_halted), 64'(0));
    repeat (6) step();

    // End of code in slot 1: entry kept with slot 0 only.
    eoc_pc = 32'h304;
    force_redir = 1'b1; force_pc = 32'h300;
    repeat (12) step();
    check("eoc1_halted", 64'(fetch_halted), 64'(1));
    eoc_en = 1'b0;

    // Asynchronous reset with two requests outstanding.
    force_redir = 1'b1; force_pc = 32'h500;
    step();
    set_probs(100, 0, 100, 0);
    wait_outstanding2("reset_setup");
    #1 reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    #2 reset_n = 1'b1;
    set_probs(100, 100, 100, 0);
    post_release();
    repeat (8) step();

    // Random traffic with occasional redirects and moving end-of-code markers.
    set_probs(70, 60, 60, 3);
    eoc_en = 1'b1;
    for (int blk = 0; blk < 15; blk++) begin
      eoc_pc = 32'($urandom_range(0, 255)) << 2;
      repeat (200) step();
    end

    @(posedge clk);
    model_edge();
    #1;
`ifdef IFU_PERF_CNT_EN
    check("perf_bundles", 64'(perf_bundles), 64'(m_bundles));
    check("perf_stall", 64'(perf_stall_cycles), 64'(m_stall));
    check("perf_flushes_end", 64'(perf_flushes), 64'(m_flushes));
`else
    check("perf_off", 64'(perf_bundles | perf_stall_cycles | 32'(perf_flushes)), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
